axis_hdr_insert_arbiter: RTL

- Packet-level round-robin arbiter that shares one axi_stream_insert_header instance between NUM_SRC requesters.
- Each requester owns a header channel and a data channel.
- The arbiter grants one requester for a whole packet and forwards its header beat, then its data beats up to and including `last`.
- It then re-arbitrates. It sits directly upstream of the header-insert block and drives both of that block's slave interfaces.

---
 rtl/axis_hdr_insert_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axis_hdr_insert_arbiter.sv
// -----------------------------------------------------------------------------
// axis_hdr_insert_arbiter
//
// Purpose:
//   Packet-level round-robin arbiter that lets NUM_SRC requesters share one
//   header-insert block. A requester is granted for one whole packet: its
//   header beat is forwarded first, then its data beats up to and including
//   `last`. After the packet the arbiter re-arbitrates, starting the search at
//   the source after the one just served. There is no buffering. While a
//   source is granted, its channels pass straight through to the outputs and
//   backpressure returns combinationally.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   s_*_insert            per-source header channels (valid/data/keep/cnt/ready)
//   s_*_in                per-source data channels (valid/data/keep/last/ready)
//   valid_insert ..       header channel towards the insert block
//   ready_insert          header ready from the insert block
//   valid_in ..           data channel towards the insert block
//   ready_in              data ready from the insert block
//   grant_idx             index of the current or most recently granted source
//   busy                  high while a packet is in flight (HDR or DATA)
//   pkt_count             completed packet counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module axis_hdr_insert_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 2,
    parameter int SRC_WD       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]       s_data_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]  s_keep_insert,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]   s_byte_insert_cnt,
    output logic [NUM_SRC-1:0]               s_ready_insert,
    input  logic [NUM_SRC-1:0]               s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]       s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]  s_keep_in,
    input  logic [NUM_SRC-1:0]               s_last_in,
    output logic [NUM_SRC-1:0]               s_ready_in,
    output logic                             valid_insert,
    output logic [DATA_WD-1:0]               data_insert,
    output logic [DATA_BYTE_WD-1:0]          keep_insert,
    output logic [BYTE_CNT_WD-1:0]           byte_insert_cnt,
    input  logic                             ready_insert,
    output logic                             valid_in,
    output logic [DATA_WD-1:0]               data_in,
    output logic [DATA_BYTE_WD-1:0]          keep_in,
    output logic                             last_in,
    input  logic                             ready_in,
    output logic [SRC_WD-1:0]                grant_idx,
    output logic                             busy,
    output logic [15:0]                      pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q;
    logic [SRC_WD-1:0]   grant_q;
    logic [SRC_WD-1:0]   rr_q;
    logic [15:0]         cnt_q;
    logic                busy_q;

    logic                pick_vld_d;
    logic [SRC_WD-1:0]   pick_idx_d;
    logic [SRC_WD-1:0]   cand;

    // Per-source views of the flattened input buses, so the granted source
    // can be selected with a plain array index.
    logic [DATA_WD-1:0]      hdr_data [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] hdr_keep [NUM_SRC];
    logic [BYTE_CNT_WD-1:0]  hdr_cnt  [NUM_SRC];
    logic [DATA_WD-1:0]      dat_data [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] dat_keep [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign hdr_data[i] = s_data_insert[i*DATA_WD +: DATA_WD];
        assign hdr_keep[i] = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        assign hdr_cnt[i]  = s_byte_insert_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        assign dat_data[i] = s_data_in[i*DATA_WD +: DATA_WD];
        assign dat_keep[i] = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
    end

    // Round-robin pick: first requesting source at or after rr_q, with wrap.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        cand       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = SRC_WD'((int'(rr_q) + k) % NUM_SRC);
            if (!pick_vld_d && s_valid_insert[cand]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand;
            end
        end
    end

    // Passthrough muxing. Only the channel belonging to the current phase is
    // opened, so data beats presented early by the granted source are held
    // off until its header has been accepted.
    always_comb begin
        s_ready_insert  = '0;
        s_ready_in      = '0;
        valid_insert    = 1'b0;
        data_insert     = '0;
        keep_insert     = '0;
        byte_insert_cnt = '0;
        valid_in        = 1'b0;
        data_in         = '0;
        keep_in         = '0;
        last_in         = 1'b0;
        case (state_q)
            HDR: begin
                valid_insert            = s_valid_insert[grant_q];
                data_insert             = hdr_data[grant_q];
                keep_insert             = hdr_keep[grant_q];
                byte_insert_cnt         = hdr_cnt[grant_q];
                s_ready_insert[grant_q] = ready_insert;
            end
            DATA: begin
                valid_in            = s_valid_in[grant_q];
                data_in             = dat_data[grant_q];
                keep_in             = dat_keep[grant_q];
                last_in             = s_last_in[grant_q];
                s_ready_in[grant_q] = ready_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        grant_q <= pick_idx_d;
                        state_q <= HDR;
                        busy_q  <= 1'b1;
                    end
                end
                HDR: begin
                    // A header valid that drops before the handshake keeps us here.
                    if (valid_insert && ready_insert) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (valid_in && ready_in && last_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        rr_q    <= (grant_q == SRC_WD'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                        cnt_q   <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_idx = grant_q;
    assign busy      = busy_q;
    assign pkt_count = cnt_q;

endmodule
